run_checker: RTL and testbench
==============================

# run_checker

Parametrised, synthesizable run-and-check sequencer that drives a multi-cycle CPU core through one self-checking program run. It holds the core in reset for a programmable number of cycles, counts retired instructions up to a step limit, stops on halt or timeout, then compares every register-file entry against an expected-value memory one entry per cycle. It sits beside the `mips` top in simulation and FPGA bring-up, and replaces hand-written per-test polling loops.

## Interface
- `NREGS`, 32: number of register-file entries to check (≥2).
- `DW`, 32: register data width.
- `AW`, $clog2(NREGS): register address width.
- `MAX_STEPS`, 100: retire limit before timeout (≥1).
- `RST_CYC`, 2: cycles `cpu_rst` is held high (≥1).
- `SW`, 16: width of `step_count` (must hold `MAX_STEPS`).

Ports:
- `clk`  in  1  sole clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset of this block.
- `start`  in  1  one-cycle pulse; starts a run when idle, ignored otherwise.
- `cpu_rst`  out  1  reset to the core under test.
- `retire`  in  1  one-cycle pulse when the core's controller re-enters fetch state (`S1`).
- `halted`  in  1  core has no valid instruction at PC (level).
- `rd_addr`  out  AW  register-file / expected-memory read address.
- `rd_data`  in  DW  combinational register-file read data for `rd_addr`.
- `exp_data`  in  DW  combinational expected value for `rd_addr`.
- `busy`  out  1  run or check in progress.
- `done`  out  1  result valid; held until next `start`.
- `pass`  out  1  valid with `done`: no mismatches and no timeout.
- `timeout`  out  1  run ended by step limit, not halt.
- `step_count`  out  SW  retires counted in the run.
- `fail_count`  out  AW+1  number of mismatching entries.
- `first_fail`  out  AW  index of the lowest mismatching entry; 0 if none.

## Operation
- States: IDLE, RESET, RUN, CHECK, DONE.
- IDLE: `cpu_rst`=1. On `start`, clear `step_count`, `fail_count`, `first_fail`, `timeout`, `done`, `pass`; go to RESET and load the reset counter with `RST_CYC`-1.
- RESET: `cpu_rst`=1. The counter decrements each cycle. At 0, go to RUN.
- RUN: `cpu_rst`=0. Each `retire` increments `step_count`.
  - Exit to CHECK when `halted`=1. `halted` has priority over `retire` in the same cycle, and that retire is still counted.
  - Exit with `timeout`=1 when the increment brings `step_count` to `MAX_STEPS`.
- CHECK: `cpu_rst`=0, so the core state is preserved. `rd_addr` counts 0..NREGS-1, one per cycle.
  - On each cycle where `rd_data` != `exp_data` (4-state: X or Z never equals a driven value), `fail_count` increments.
  - On the first mismatch, `first_fail` is set to `rd_addr`.
  - After address NREGS-1, go to DONE.
- DONE: `done`=1; `pass` = (`fail_count`==0) && !`timeout`. `cpu_rst` stays 0 and the outputs hold. `start` begins a new run, going straight to RESET.
- `start` in RESET, RUN or CHECK is ignored.
- `rd_addr` is 0 outside CHECK.

## Timing
- Reset values: state IDLE, `cpu_rst`=1, `busy`=0, `done`=0, `pass`=0, `timeout`=0, `step_count`=0, `fail_count`=0, `first_fail`=0, `rd_addr`=0.
- `rst` asserted mid-run returns the block to IDLE immediately, without waiting for a clock edge. The core is then held in reset.
- `start` at edge k: `cpu_rst` is high for exactly `RST_CYC` cycles after edge k, then low from edge k+`RST_CYC`.
- `busy` is high from edge k until the edge entering DONE.
- CHECK takes exactly `NREGS` cycles. `done` rises at the edge after the last comparison.
- All outputs are registered except `rd_addr`, which is the state-held counter.

## Structure
- Shared package `tb_pkg`: state enum `run_state_t`, and the fetch-state encoding `S1` already used by the controller.
- One natural sub-module: `reg_compare_scan`. It owns the address counter, the mismatch counter and first-fail capture, with `go`/`finished` handshake to the FSM.

## Test plan
- Program halts after 7 retires with all expected values matching → `step_count`=7, `timeout`=0, `fail_count`=0, `pass`=1, `done`=1 after 32 CHECK cycles.
- Program loops forever with `MAX_STEPS`=100 → `timeout`=1 at the 100th retire, then CHECK still runs, and `pass`=0.
- Expected values differ at entries 3 and 17 → `fail_count`=2, `first_fail`=3, `pass`=0.
- Entry 5 of `rd_data` reads X → counted as a mismatch, `first_fail`=5.
- `RST_CYC`=4 → `cpu_rst` is high for exactly 4 cycles after `start`.
- `start` pulses during RUN are ignored. Asserting `rst` mid-CHECK → IDLE with all outputs at reset values. A following `start` then runs cleanly.

Source files
------------

// File: rtl/tb_pkg.sv
// Shared types for the run-and-check sequencer.
// Also carries the core controller's fetch-state encoding.
package tb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_CHECK,
    ST_DONE
  } run_state_t;

  // Controller state that marks instruction retirement
  localparam logic [3:0] S1 = 4'd1;

endpackage

// File: rtl/run_checker_scan.sv
// Register-file scanner: walks every entry once,
// counts mismatches and captures the lowest failing index.
module reg_compare_scan
  import tb_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int DW    = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          go,
  input  logic [DW-1:0] rd_data,
  input  logic [DW-1:0] exp_data,
  output logic [AW-1:0] rd_addr,
  output logic          finished,
  output logic          mismatch,
  output logic [AW:0]   fail_count,
  output logic [AW-1:0] first_fail
);

  logic          active_q, active_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   fail_q, fail_d;
  logic [AW-1:0] first_q, first_d;
  logic          last;

  always_comb begin
    active_d = active_q;
    addr_d   = addr_q;
    fail_d   = fail_q;
    first_d  = first_q;
    last     = (addr_q == AW'(NREGS - 1));
    // 4-state compare: an undriven read never matches
    mismatch = active_q && (rd_data !== exp_data);
    finished = active_q && last;
    if (clr) begin
      active_d = 1'b0;
      addr_d   = '0;
      fail_d   = '0;
      first_d  = '0;
    end else if (go) begin
      active_d = 1'b1;
      addr_d   = '0;
    end else if (active_q) begin
      if (mismatch) begin
        fail_d = fail_q + 1'b1;
        if (fail_q == '0) begin
          first_d = addr_q;
        end
      end
      if (last) begin
        active_d = 1'b0;
        addr_d   = '0;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      addr_q   <= '0;
      fail_q   <= '0;
      first_q  <= '0;
    end else begin
      active_q <= active_d;
      addr_q   <= addr_d;
      fail_q   <= fail_d;
      first_q  <= first_d;
    end
  end

  assign rd_addr    = addr_q;
  assign fail_count = fail_q;
  assign first_fail = first_q;

endmodule

// File: rtl/run_checker.sv
// Run-and-check sequencer: resets the core, runs it to halt
// or step limit, then scans the register file against expectations.
module run_checker
  import tb_pkg::*;
#(
  parameter int NREGS     = 32,
  parameter int DW        = 32,
  parameter int AW        = $clog2(NREGS),
  parameter int MAX_STEPS = 100,
  parameter int RST_CYC   = 2,
  parameter int SW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          cpu_rst,
  input  logic          retire,
  input  logic          halted,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  input  logic [DW-1:0] exp_data,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [SW-1:0] step_count,
  output logic [AW:0]   fail_count,
  output logic [AW-1:0] first_fail
);

  localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  run_state_t     state_q, state_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic [SW-1:0]  step_q, step_d;
  logic [SW-1:0]  step_inc;
  logic           timeout_q, timeout_d;
  logic           cpu_rst_q, cpu_rst_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic           clr, go;
  logic           finished, mismatch;
  logic [AW:0]    fail_cnt;

  reg_compare_scan #(
    .NREGS(NREGS),
    .DW   (DW),
    .AW   (AW)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .go        (go),
    .rd_data   (rd_data),
    .exp_data  (exp_data),
    .rd_addr   (rd_addr),
    .finished  (finished),
    .mismatch  (mismatch),
    .fail_count(fail_cnt),
    .first_fail(first_fail)
  );

  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    step_d    = step_q;
    timeout_d = timeout_q;
    done_d    = done_q;
    pass_d    = pass_q;
    clr       = 1'b0;
    go        = 1'b0;
    step_inc  = step_q + 1'b1;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clr       = 1'b1;
          step_d    = '0;
          timeout_d = 1'b0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          rcnt_d    = RCW'(RST_CYC - 1);
          state_d   = ST_RESET;
        end
      end
      ST_RESET: begin
        if (rcnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          rcnt_d = rcnt_q - 1'b1;
        end
      end
      ST_RUN: begin
        if (retire) begin
          step_d = step_inc;
        end
        // Halt wins over a simultaneous limit hit
        if (halted) begin
          go      = 1'b1;
          state_d = ST_CHECK;
        end else if (retire && step_inc == SW'(MAX_STEPS)) begin
          go        = 1'b1;
          timeout_d = 1'b1;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (finished) begin
          done_d  = 1'b1;
          pass_d  = (fail_cnt == '0) && !mismatch && !timeout_q;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cpu_rst_d = (state_d == ST_IDLE) || (state_d == ST_RESET);
    busy_d    = (state_d == ST_RESET) || (state_d == ST_RUN) ||
                (state_d == ST_CHECK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rcnt_q    <= '0;
      step_q    <= '0;
      timeout_q <= 1'b0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      step_q    <= step_d;
      timeout_q <= timeout_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign cpu_rst    = cpu_rst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign timeout    = timeout_q;
  assign step_count = step_q;
  assign fail_count = fail_cnt;

endmodule

// File: tb/tb_run_checker.sv
// Directed bench for run_checker: halt, timeout, mismatches,
// X reads, reset length, ignored starts and async reset.
module tb_run_checker;

  localparam int NREGS = 32;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int SW    = 16;

  logic          clk, rst, start, retire, halted;
  logic          cpu_rst, busy, done, pass, timeout;
  logic [AW-1:0] rd_addr, first_fail;
  logic [DW-1:0] rd_data, exp_data;
  logic [SW-1:0] step_count;
  logic [AW:0]   fail_count;
  logic [DW-1:0] rf [NREGS];
  logic [DW-1:0] em [NREGS];

  int checks   = 0;
  int failures = 0;

  assign rd_data  = rf[rd_addr];
  assign exp_data = em[rd_addr];

  run_checker #(
    .NREGS    (NREGS),
    .DW       (DW),
    .AW       (AW),
    .MAX_STEPS(100),
    .RST_CYC  (4),
    .SW       (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cpu_rst   (cpu_rst),
    .retire    (retire),
    .halted    (halted),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .exp_data  (exp_data),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .step_count(step_count),
    .fail_count(fail_count),
    .first_fail(first_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic fill_match();
    for (int i = 0; i < NREGS; i++) begin
      em[i] = 32'hA5A5_0000 + 32'(i);
      rf[i] = 32'hA5A5_0000 + 32'(i);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_retires(input int n);
    for (int i = 0; i < n; i++) begin
      retire = 1'b1;
      @(negedge clk);
      retire = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    @(negedge clk);
    while (!done && n < 300) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    retire = 1'b0;
    halted = 1'b0;
    fill_match();
    @(negedge clk);
    checks++;
    if ({cpu_rst, busy, done, pass, timeout} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=10000",
               {cpu_rst, busy, done, pass, timeout});
    end
    checks++;
    if ({step_count, fail_count, first_fail, rd_addr} !== '0) begin
      failures++;
      $display("FAIL reset_counts step=%0d fail=%0d first=%0d addr=%0d exp=0",
               step_count, fail_count, first_fail, rd_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_halt_pass();
    int n;
    pulse_start();
    n = 0;
    while (cpu_rst && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL rst_cycles got=%0d exp=4", n);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL run_busy got=%b exp=1", busy);
    end
    do_retires(7);
    halted = 1'b1;
    wait_done(n);
    checks++;
    if (n != NREGS) begin
      failures++;
      $display("FAIL check_cycles got=%0d exp=%0d", n, NREGS);
    end
    checks++;
    if ({done, pass, timeout, busy, cpu_rst} !== 5'b11000) begin
      failures++;
      $display("FAIL halt_flags got=%b exp=11000",
               {done, pass, timeout, busy, cpu_rst});
    end
    checks++;
    if (step_count !== 16'd7 || fail_count !== 6'd0) begin
      failures++;
      $display("FAIL halt_counts step=%0d fail=%0d exp=7,0",
               step_count, fail_count);
    end
  endtask

  task automatic test_timeout();
    int n;
    halted = 1'b0;
    pulse_start();
    repeat (4) @(negedge clk);
    retire = 1'b1;
    repeat (99) @(negedge clk);
    checks++;
    if (step_count !== 16'd99 || timeout !== 1'b0 || busy !== 1'b1
        || rd_addr !== 5'd0) begin
      failures++;
      $display("FAIL pre_limit step=%0d to=%b busy=%b addr=%0d exp=99,0,1,0",
               step_count, timeout, busy, rd_addr);
    end
    @(negedge clk);
    retire = 1'b0;
    checks++;
    if (step_count !== 16'd100 || timeout !== 1'b1) begin
      failures++;
      $display("FAIL at_limit step=%0d to=%b exp=100,1",
               step_count, timeout);
    end
    wait_done(n);
    checks++;
    if ({done, pass, timeout} !== 3'b101 || fail_count !== 6'd0) begin
      failures++;
      $display("FAIL timeout_result flags=%b fail=%0d exp=101,0",
               {done, pass, timeout}, fail_count);
    end
  endtask

  task automatic test_mismatch();
    int n;
    halted = 1'b0;
    em[3]  = 32'h1234_5678;
    em[17] = 32'h0;
    pulse_start();
    repeat (4) @(negedge clk);
    do_retires(3);
    retire = 1'b1;
    halted = 1'b1;
    @(negedge clk);
    retire = 1'b0;
    wait_done(n);
    checks++;
    if (fail_count !== 6'd2 || first_fail !== 5'd3) begin
      failures++;
      $display("FAIL mismatch_counts fail=%0d first=%0d exp=2,3",
               fail_count, first_fail);
    end
    checks++;
    if ({done, pass, timeout} !== 3'b100 || step_count !== 16'd4) begin
      failures++;
      $display("FAIL mismatch_flags flags=%b step=%0d exp=100,4",
               {done, pass, timeout}, step_count);
    end
    fill_match();
  endtask

  task automatic test_x_read();
    int n;
    rf[5] = 'x;
    halted = 1'b1;
    pulse_start();
    checks++;
    if ({done, cpu_rst, busy} !== 3'b011) begin
      failures++;
      $display("FAIL back_to_back flags=%b exp=011", {done, cpu_rst, busy});
    end
    wait_done(n);
    checks++;
    if (fail_count !== 6'd1 || first_fail !== 5'd5 || pass !== 1'b0
        || step_count !== 16'd0) begin
      failures++;
      $display("FAIL x_read fail=%0d first=%0d pass=%b step=%0d exp=1,5,0,0",
               fail_count, first_fail, pass, step_count);
    end
    fill_match();
  endtask

  task automatic test_ignored_start_and_rst();
    int n;
    halted = 1'b0;
    pulse_start();
    repeat (4) @(negedge clk);
    retire = 1'b1;
    @(negedge clk);
    retire = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    retire = 1'b1;
    start = 1'b1;
    @(negedge clk);
    retire = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (step_count !== 16'd2 || cpu_rst !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL start_in_run step=%0d crst=%b busy=%b exp=2,0,1",
               step_count, cpu_rst, busy);
    end
    halted = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (rd_addr !== 5'd9) begin
      failures++;
      $display("FAIL check_addr got=%0d exp=9", rd_addr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cpu_rst, busy, done, pass, timeout} !== 5'b10000
        || {step_count, fail_count, first_fail, rd_addr} !== '0) begin
      failures++;
      $display("FAIL async_rst flags=%b step=%0d addr=%0d exp=10000,0,0",
               {cpu_rst, busy, done, pass, timeout}, step_count, rd_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    halted = 1'b0;
    pulse_start();
    repeat (4) @(negedge clk);
    do_retires(5);
    halted = 1'b1;
    wait_done(n);
    checks++;
    if ({done, pass, timeout} !== 3'b110 || step_count !== 16'd5
        || fail_count !== 6'd0) begin
      failures++;
      $display("FAIL rerun flags=%b step=%0d fail=%0d exp=110,5,0",
               {done, pass, timeout}, step_count, fail_count);
    end
  endtask

  initial begin
    test_reset();
    test_halt_pass();
    test_timeout();
    test_mismatch();
    test_x_read();
    test_ignored_start_and_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
